// File: rtl/serial_xfer_pkg.sv
// Shared definitions for the serial transfer controller.
//
// Contents:
//   xferState_t     - transfer sequencer states
//   CPOL_* / CPHA_* - named serial clock mode settings
//   clampBitCount   - maps a requested transfer length onto 1..width
//
// Optional feature macro used by the controller: SERIAL_XFER_ABORT_EN
package serial_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETUP,
      LEAD,
      TRAIL,
      HOLD
   } xferState_t;

   // Idle level of the serial clock
   localparam logic CPOL_IDLE_LOW  = 1'b0;
   localparam logic CPOL_IDLE_HIGH = 1'b1;

   // Which half-period edge samples the incoming data
   localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
   localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

   // A length of zero, or one longer than the shift register, means a full-width transfer
   function automatic int clampBitCount(input int requested, input int width);
      if (requested == 0 || requested > width) begin
         return width;
      end
      return requested;
   endfunction

endpackage

// File: rtl/serial_clock_divider.sv
// Half-period timebase for the serial transfer controller.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   restart in   holds the count at zero so the next half-period starts cleanly
//   divider in   half-period length minus one (H = divider + 1)
//   tick    out  high in the last cycle of a half-period; the following clk edge
//                starts the next H-cycle half-period
module serial_clock_divider #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] divider,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] count_q;
   logic [DIV_WIDTH-1:0] count_d;

   // The count runs 0..divider and wraps; comparing against divider instead of
   // counting to divider+1 lets an all-ones divider give H = 2^DIV_WIDTH without
   // needing an extra counter bit.
   always_comb begin
      count_d = count_q + 1'b1;
      if (restart || (count_q == divider)) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = !restart && (count_q == divider);

endmodule

// File: rtl/serial_transfer_controller.sv
// Transfer sequencer for the SPI-style peripheral path. Drives the shift register
// strobes, generates sclk and cs_n, and reports completion.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           transfer request, accepted only while busy = 0
//   divider         half-period length minus one in clk cycles
//   bitCount        bits per transfer (0 or > WIDTH means WIDTH)
//   cpol, cpha      serial clock idle level and sampling edge
//   msbFirstCfg     requested bit order
//   loadEnable      one-cycle parallel load strobe
//   shiftInEnable   one-cycle sample strobe
//   shiftOutEnable  one-cycle output-update strobe
//   msbFirst        bit order latched for the running transfer
//   sclk, cs_n      serial clock and active-low chip select
//   busy, done      transfer in progress / one-cycle completion pulse
//   abort, aborted  early termination request and its one-cycle acknowledge
//                   (present only when SERIAL_XFER_ABORT_EN is defined)
//
// Optional feature macro: SERIAL_XFER_ABORT_EN
module serial_transfer_controller
   import serial_xfer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [DIV_WIDTH-1:0]       divider,
   input  logic [$clog2(WIDTH+1)-1:0] bitCount,
   input  logic                       cpol,
   input  logic                       cpha,
   input  logic                       msbFirstCfg,
   output logic                       loadEnable,
   output logic                       shiftInEnable,
   output logic                       shiftOutEnable,
   output logic                       msbFirst,
   output logic                       sclk,
   output logic                       cs_n,
   output logic                       busy,
   output logic                       done
`ifdef SERIAL_XFER_ABORT_EN
   ,
   input  logic                       abort,
   output logic                       aborted
`endif
);

   localparam int BCW = $clog2(WIDTH + 1);

   xferState_t state_q, state_d;

   logic [DIV_WIDTH-1:0] divCfg_q, divCfg_d;
   logic [BCW-1:0]       lenCfg_q, lenCfg_d;
   logic                 cpolCfg_q, cpolCfg_d;
   logic                 cphaCfg_q, cphaCfg_d;
   logic                 msbCfg_q, msbCfg_d;
   logic [BCW-1:0]       bitCnt_q, bitCnt_d;

   logic loadEnable_q, loadEnable_d;
   logic shiftIn_q, shiftIn_d;
   logic shiftOut_q, shiftOut_d;
   logic msbFirst_q, msbFirst_d;
   logic sclk_q, sclk_d;
   logic csN_q, csN_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic aborted_d;

   logic tick;
   logic restart;
   logic accept;
   logic abortHit;
   logic finish;
   logic enterHalf;
   logic sampleLead;

   // The timebase is held at zero until the sequencer leaves LOAD, so the first
   // SETUP cycle is always the first cycle of a fresh half-period.
   assign restart = (state_q == IDLE) || (state_q == LOAD);

   serial_clock_divider #(
      .DIV_WIDTH(DIV_WIDTH)
   ) clockDivider (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .divider(divCfg_q),
      .tick   (tick)
   );

`ifdef SERIAL_XFER_ABORT_EN
   assign abortHit = abort && (state_q != IDLE);
`else
   assign abortHit = 1'b0;
`endif

   // Next-state and next-output logic. Every output is computed here for the
   // state being entered and then registered, so outputs line up with the state
   // they describe and never see an input combinationally. Configuration values
   // are taken from their _d copies so the LOAD cycle already reflects the
   // settings accepted with start.
   always_comb begin
      accept    = (state_q == IDLE) && start;
      divCfg_d  = accept ? divider     : divCfg_q;
      lenCfg_d  = accept ? bitCount    : lenCfg_q;
      cpolCfg_d = accept ? cpol        : cpolCfg_q;
      cphaCfg_d = accept ? cpha        : cphaCfg_q;
      msbCfg_d  = accept ? msbFirstCfg : msbCfg_q;

      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      finish   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d  = SETUP;
            bitCnt_d = BCW'(clampBitCount(int'(lenCfg_q), WIDTH));
         end
         SETUP: begin
            if (tick) begin
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (tick) begin
               state_d  = TRAIL;
               bitCnt_d = bitCnt_q - 1'b1;
            end
         end
         TRAIL: begin
            if (tick) begin
               state_d = (bitCnt_q == '0) ? HOLD : LEAD;
            end
         end
         HOLD: begin
            if (tick) begin
               state_d = IDLE;
               finish  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An abort overrides any pending transition and suppresses completion
      if (abortHit) begin
         state_d = IDLE;
         finish  = 1'b0;
      end

      // LEAD and TRAIL always alternate, so any state change into them marks
      // the first cycle of a half-period
      enterHalf  = (state_d != state_q);
      sampleLead = (cphaCfg_d == CPHA_SAMPLE_LEAD);

      sclk_d       = (state_d == LEAD) ? ~cpolCfg_d : cpolCfg_d;
      shiftIn_d    = enterHalf && (((state_d == LEAD) && sampleLead) ||
                                   ((state_d == TRAIL) && !sampleLead));
      shiftOut_d   = enterHalf && (((state_d == TRAIL) && sampleLead) ||
                                   ((state_d == LEAD) && !sampleLead));
      loadEnable_d = (state_d == LOAD);
      csN_d        = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      done_d       = finish;
      msbFirst_d   = (state_d != IDLE) && msbCfg_d;
      aborted_d    = abortHit;
   end

   // State, configuration and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         divCfg_q     <= '0;
         lenCfg_q     <= '0;
         cpolCfg_q    <= CPOL_IDLE_LOW;
         cphaCfg_q    <= CPHA_SAMPLE_LEAD;
         msbCfg_q     <= 1'b0;
         bitCnt_q     <= '0;
         loadEnable_q <= 1'b0;
         shiftIn_q    <= 1'b0;
         shiftOut_q   <= 1'b0;
         msbFirst_q   <= 1'b0;
         sclk_q       <= CPOL_IDLE_LOW;
         csN_q        <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         divCfg_q     <= divCfg_d;
         lenCfg_q     <= lenCfg_d;
         cpolCfg_q    <= cpolCfg_d;
         cphaCfg_q    <= cphaCfg_d;
         msbCfg_q     <= msbCfg_d;
         bitCnt_q     <= bitCnt_d;
         loadEnable_q <= loadEnable_d;
         shiftIn_q    <= shiftIn_d;
         shiftOut_q   <= shiftOut_d;
         msbFirst_q   <= msbFirst_d;
         sclk_q       <= sclk_d;
         csN_q        <= csN_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef SERIAL_XFER_ABORT_EN
   logic aborted_q;

   // One-cycle acknowledge of an accepted abort
   always_ff @(posedge clk) begin
      if (rst) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= aborted_d;
      end
   end

   assign aborted = aborted_q;
`else
   logic unusedAbort;
   assign unusedAbort = aborted_d;
`endif

   assign loadEnable     = loadEnable_q;
   assign shiftInEnable  = shiftIn_q;
   assign shiftOutEnable = shiftOut_q;
   assign msbFirst       = msbFirst_q;
   assign sclk           = sclk_q;
   assign cs_n           = csN_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_serial_transfer_controller.sv
// Directed self-checking bench for serial_transfer_controller. A small
// transaction-level shift register model loops serialOut back to serialIn so the
// strobe ordering can be checked by the returned data.
module tb_serial_transfer_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] divider;
   logic [3:0] bitCount;
   logic       cpol;
   logic       cpha;
   logic       msbFirstCfg;
   logic       loadEnable;
   logic       shiftInEnable;
   logic       shiftOutEnable;
   logic       msbFirst;
   logic       sclk;
   logic       cs_n;
   logic       busy;
   logic       done;
`ifdef SERIAL_XFER_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   int errors = 0;
   int checks = 0;

   // Results gathered by observeTransfer
   int         csLow;
   int         leadEdges;
   int         inCnt;
   int         outCnt;
   int         misplaced;
   int         minGap;
   int         maxGap;
   int         badSamples;
   logic       doneSeen;
   logic       doneBusy;
   logic       doneCsN;
   logic [7:0] rxVal;

   serial_transfer_controller #(
      .WIDTH    (8),
      .DIV_WIDTH(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .divider       (divider),
      .bitCount      (bitCount),
      .cpol          (cpol),
      .cpha          (cpha),
      .msbFirstCfg   (msbFirstCfg),
      .loadEnable    (loadEnable),
      .shiftInEnable (shiftInEnable),
      .shiftOutEnable(shiftOutEnable),
      .msbFirst      (msbFirst),
      .sclk          (sclk),
      .cs_n          (cs_n),
      .busy          (busy),
      .done          (done)
`ifdef SERIAL_XFER_ABORT_EN
      ,
      .abort         (abort),
      .aborted       (aborted)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents a configuration with start for one cycle; returns at the negedge of
   // the cycle in which loadEnable should be high.
   task automatic applyStimulus(input logic [7:0] div, input logic [3:0] bc,
                                input logic pol, input logic pha, input logic msb);
      divider     = div;
      bitCount    = bc;
      cpol        = pol;
      cpha        = pha;
      msbFirstCfg = msb;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   function automatic int bitPos(input int j, input int n, input logic msb);
      return msb ? (n - 1 - j) : j;
   endfunction

   // Follows a transfer from the LOAD cycle until done (or the budget expires).
   task automatic observeTransfer(input int n, input logic [7:0] txVal, input logic pol,
                                  input logic pha, input logic msb, input int budget);
      logic prevSclk;
      int   lastEdge;
      int   outIdx;
      int   gap;
      csLow      = 0;
      leadEdges  = 0;
      inCnt      = 0;
      outCnt     = 0;
      misplaced  = 0;
      minGap     = 1000;
      maxGap     = 0;
      badSamples = 0;
      doneSeen   = 1'b0;
      doneBusy   = 1'bx;
      doneCsN    = 1'bx;
      rxVal      = 8'h00;
      prevSclk   = sclk;
      lastEdge   = -1;
      outIdx     = pha ? -1 : 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (!cs_n) csLow++;
         if (sclk !== prevSclk) begin
            if (lastEdge >= 0) begin
               gap = cyc - lastEdge;
               if (gap < minGap) minGap = gap;
               if (gap > maxGap) maxGap = gap;
            end
            lastEdge = cyc;
            if (sclk !== pol) leadEdges++;
         end
         if ((shiftInEnable || shiftOutEnable) && (sclk === prevSclk)) misplaced++;
         if (shiftOutEnable) begin
            outCnt++;
            outIdx++;
         end
         if (shiftInEnable) begin
            if (outIdx >= 0 && outIdx < n && inCnt < n)
               rxVal[bitPos(inCnt, n, msb)] = txVal[bitPos(outIdx, n, msb)];
            else
               badSamples++;
            inCnt++;
         end
         prevSclk = sclk;
         if (done) begin
            doneSeen = 1'b1;
            doneBusy = busy;
            doneCsN  = cs_n;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int trails;
      int doneCount;
      logic prev;

      rst         = 1'b1;
      start       = 1'b0;
      divider     = 8'd0;
      bitCount    = 4'd8;
      cpol        = 1'b0;
      cpha        = 1'b0;
      msbFirstCfg = 1'b0;
`ifdef SERIAL_XFER_ABORT_EN
      abort       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values
      checkOutput("reset cs_n", cs_n, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset sclk", sclk, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset strobes", {loadEnable, shiftInEnable, shiftOutEnable}, 0);
      checkOutput("reset msbFirst", msbFirst, 0);

      // Mode 0, MSB first, H = 1, 8 bits of 0xA5
      @(negedge clk);
      applyStimulus(8'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      checkOutput("m0 loadEnable", loadEnable, 1);
      checkOutput("m0 load cs_n", cs_n, 0);
      checkOutput("m0 load busy", busy, 1);
      checkOutput("m0 msbFirst", msbFirst, 1);
      observeTransfer(8, 8'hA5, 1'b0, 1'b0, 1'b1, 200);
      checkOutput("m0 done seen", doneSeen, 1);
      checkOutput("m0 sclk pulses", leadEdges, 8);
      checkOutput("m0 cs_n low", csLow, 19);
      checkOutput("m0 rx data", rxVal, 8'hA5);
      checkOutput("m0 in strobes", inCnt, 8);
      checkOutput("m0 out strobes", outCnt, 8);
      checkOutput("m0 misplaced strobes", misplaced, 0);
      checkOutput("m0 bad samples", badSamples, 0);
      checkOutput("m0 done cs_n", doneCsN, 1);
      checkOutput("m0 done busy", doneBusy, 0);
      @(negedge clk);
      checkOutput("m0 done single", done, 0);
      checkOutput("m0 idle msbFirst", msbFirst, 0);

      // Mode 3, LSB first, H = 4, 5 bits of 0x13; inputs changed after start
      checkOutput("m3 pre sclk", sclk, 0);
      applyStimulus(8'd3, 4'd5, 1'b1, 1'b1, 1'b0);
      checkOutput("m3 load sclk", sclk, 1);
      divider     = 8'd0;
      bitCount    = 4'd1;
      cpol        = 1'b0;
      cpha        = 1'b0;
      msbFirstCfg = 1'b1;
      observeTransfer(5, 8'h13, 1'b1, 1'b1, 1'b0, 400);
      checkOutput("m3 done seen", doneSeen, 1);
      checkOutput("m3 sclk pulses", leadEdges, 5);
      checkOutput("m3 min half", minGap, 4);
      checkOutput("m3 max half", maxGap, 4);
      checkOutput("m3 cs_n low", csLow, 49);
      checkOutput("m3 rx data", rxVal, 8'h13);
      checkOutput("m3 misplaced strobes", misplaced, 0);
      checkOutput("m3 bad samples", badSamples, 0);
      @(negedge clk);
      checkOutput("m3 idle sclk", sclk, 1);

      // Length clamping, with a back-to-back start in the done cycle
      applyStimulus(8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      observeTransfer(8, 8'h3C, 1'b0, 1'b0, 1'b1, 200);
      checkOutput("len0 done seen", doneSeen, 1);
      checkOutput("len0 sclk pulses", leadEdges, 8);
      checkOutput("len0 cs_n low", csLow, 19);
      checkOutput("len0 rx data", rxVal, 8'h3C);
      applyStimulus(8'd0, 4'd9, 1'b0, 1'b0, 1'b1);
      checkOutput("b2b loadEnable", loadEnable, 1);
      observeTransfer(8, 8'hC3, 1'b0, 1'b0, 1'b1, 200);
      checkOutput("len9 done seen", doneSeen, 1);
      checkOutput("len9 sclk pulses", leadEdges, 8);
      checkOutput("len9 rx data", rxVal, 8'hC3);

      // Reset asserted in the third TRAIL half-period
      @(negedge clk);
      applyStimulus(8'd1, 4'd8, 1'b0, 1'b0, 1'b1);
      trails = 0;
      prev   = sclk;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (sclk !== prev && sclk === 1'b0) trails++;
         prev = sclk;
         if (trails == 3) break;
      end
      checkOutput("rst trails reached", trails, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst cs_n", cs_n, 1);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst strobes", {loadEnable, shiftInEnable, shiftOutEnable}, 0);
      doneCount = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("rst no done", doneCount, 0);
      checkOutput("rst stays idle", busy, 0);

`ifdef SERIAL_XFER_ABORT_EN
      // Abort during LEAD, then a fresh transfer
      applyStimulus(8'd1, 4'd8, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 20; c++) begin
         if (sclk === 1'b1) break;
         @(negedge clk);
      end
      checkOutput("abt in lead", sclk, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abt aborted", aborted, 1);
      checkOutput("abt cs_n", cs_n, 1);
      checkOutput("abt sclk", sclk, 0);
      checkOutput("abt done", done, 0);
      @(negedge clk);
      checkOutput("abt pulse once", aborted, 0);
      applyStimulus(8'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      checkOutput("abt restart load", loadEnable, 1);
      observeTransfer(8, 8'h5A, 1'b0, 1'b0, 1'b1, 200);
      checkOutput("abt restart done", doneSeen, 1);
      checkOutput("abt restart cs_n low", csLow, 19);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
